// File: rtl/n_decoder_pulse_pkg.sv
// Shared types and sizing helpers for the pulse decoder family.
package decoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Width of a down-counter that must hold values 0..hold.
  function automatic int cnt_width(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/n_decoder_pulse_onehot_dec.sv
// Combinational N-to-2**N binary-to-one-hot decoder.
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]      code,
  output logic [2**N-1:0]   y
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**N; gi++) begin : g_line
      assign y[gi] = (code == N'(gi));
    end
  endgenerate

endmodule

// File: rtl/n_decoder_pulse.sv
// Accepts a binary code over valid/ready and drives its one-hot line for
// HOLD cycles, with back-to-back reload, flush abort and a done pulse.
module n_decoder_pulse
  import decoder_pkg::*;
#(
  parameter int N    = 3,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [N-1:0]      code,
  input  logic              flush,
  output logic [2**N-1:0]   y,
  output logic              busy,
  output logic              done
);

  localparam int            CW   = cnt_width(HOLD);
  localparam logic [CW-1:0] LOAD = CW'(HOLD - 1);

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [N-1:0]      code_q;
  logic              xfer;
  logic              last_cycle;
  logic [N-1:0]      dec_code;
  logic [2**N-1:0]   dec_y;

  assign last_cycle = (state_reg == DRIVE) && (cnt_reg == '0);
  assign code_ready = (state_reg == IDLE) || (cnt_reg == '0);
  assign xfer       = code_valid && code_ready && !flush;
  assign busy       = (state_reg == DRIVE);

  // A fresh code goes straight into the y register; otherwise the held code is re-decoded.
  assign dec_code = xfer ? code : code_q;

  onehot_dec #(.N(N)) u_dec (
    .code (dec_code),
    .y    (dec_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      code_q    <= '0;
      y         <= '0;
      done      <= 1'b0;
    end else if (flush) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      y         <= '0;
      done      <= 1'b0;
    end else begin
      done <= last_cycle;
      if (xfer) begin
        code_q    <= code;
        y         <= dec_y;
        cnt_reg   <= LOAD;
        state_reg <= DRIVE;
      end else if (state_reg == DRIVE) begin
        if (cnt_reg == '0) begin
          y         <= '0;
          state_reg <= IDLE;
        end else begin
          y       <= dec_y;
          cnt_reg <= cnt_reg - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_n_decoder_pulse.sv
// Scoreboard bench for n_decoder_pulse in three configurations:
// (N=3,HOLD=4), (N=3,HOLD=1) and (N=4,HOLD=2).
module tb_n_decoder_pulse;

  typedef struct packed {
    logic [15:0] y;
    logic        done;
    logic        busy;
    logic        ready;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid = 0, a_flush = 0, a_ready, a_busy, a_done;
  logic [2:0] a_code = 0;
  logic [7:0] a_y;
  logic       b_valid = 0, b_flush = 0, b_ready, b_busy, b_done;
  logic [2:0] b_code = 0;
  logic [7:0] b_y;
  logic       c_valid = 0, c_flush = 0, c_ready, c_busy, c_done;
  logic [3:0] c_code = 0;
  logic [15:0] c_y;

  n_decoder_pulse #(.N(3), .HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .code_valid(a_valid), .code_ready(a_ready),
    .code(a_code), .flush(a_flush), .y(a_y), .busy(a_busy), .done(a_done));
  n_decoder_pulse #(.N(3), .HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .code_valid(b_valid), .code_ready(b_ready),
    .code(b_code), .flush(b_flush), .y(b_y), .busy(b_busy), .done(b_done));
  n_decoder_pulse #(.N(4), .HOLD(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .code_valid(c_valid), .code_ready(c_ready),
    .code(c_code), .flush(c_flush), .y(c_y), .busy(c_busy), .done(c_done));

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int checks = 0;
  int passes = 0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Monitors: one expected record per cycle, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin : pop_a
      exp_t e;
      e = qa.pop_front();
      cmp("a.y", 16'(a_y), e.y);
      cmp("a.done", 16'(a_done), 16'(e.done));
      cmp("a.busy", 16'(a_busy), 16'(e.busy));
      cmp("a.ready", 16'(a_ready), 16'(e.ready));
      $display("a: y=%02h done=%0b busy=%0b ready=%0b", a_y, a_done, a_busy, a_ready);
    end
    if (qb.size() > 0) begin : pop_b
      exp_t e;
      e = qb.pop_front();
      cmp("b.y", 16'(b_y), e.y);
      cmp("b.done", 16'(b_done), 16'(e.done));
      cmp("b.busy", 16'(b_busy), 16'(e.busy));
      cmp("b.ready", 16'(b_ready), 16'(e.ready));
      $display("b: y=%02h done=%0b busy=%0b ready=%0b", b_y, b_done, b_busy, b_ready);
    end
    if (qc.size() > 0) begin : pop_c
      exp_t e;
      e = qc.pop_front();
      cmp("c.y", c_y, e.y);
      cmp("c.done", 16'(c_done), 16'(e.done));
      cmp("c.busy", 16'(c_busy), 16'(e.busy));
      cmp("c.ready", 16'(c_ready), 16'(e.ready));
      $display("c: y=%04h done=%0b busy=%0b ready=%0b", c_y, c_done, c_busy, c_ready);
    end
  end

  // y must be one-hot or zero at all times on every instance.
  always @(negedge clk) begin
    checks++;
    if ($onehot0(a_y) && $onehot0(b_y) && $onehot0(c_y)) passes++;
    else $display("FAIL onehot t=%0t: got a=%0h b=%0h c=%0h required one-hot or zero",
                  $time, a_y, b_y, c_y);
  end

  task automatic step_a(input logic v, input logic [2:0] cd, input logic f,
                        input logic [7:0] ey, input logic ed, input logic eb, input logic er);
    @(negedge clk);
    a_valid = v; a_code = cd; a_flush = f;
    qa.push_back(exp_t'{16'(ey), ed, eb, er});
  endtask

  task automatic step_b(input logic v, input logic [2:0] cd,
                        input logic [7:0] ey, input logic ed, input logic eb, input logic er);
    @(negedge clk);
    b_valid = v; b_code = cd; b_flush = 1'b0;
    qb.push_back(exp_t'{16'(ey), ed, eb, er});
  endtask

  task automatic step_c(input logic v, input logic [3:0] cd,
                        input logic [15:0] ey, input logic ed, input logic eb, input logic er);
    @(negedge clk);
    c_valid = v; c_code = cd; c_flush = 1'b0;
    qc.push_back(exp_t'{ey, ed, eb, er});
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, ".y"}, 16'(a_y), 16'h0000);
    cmp({tag, ".busy"}, 16'(a_busy), 16'h0000);
    cmp({tag, ".done"}, 16'(a_done), 16'h0000);
    cmp({tag, ".ready"}, 16'(a_ready), 16'h0001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset sweep
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step_a(0, 3'd5, 0, 8'h00, 0, 0, 1);
    step_a(0, 3'd5, 0, 8'h00, 0, 0, 1);

    // Single transfer of code 3
    step_a(1, 3'd3, 0, 8'h08, 0, 1, 0);
    step_a(0, 3'd1, 0, 8'h08, 0, 1, 0);
    step_a(0, 3'd1, 0, 8'h08, 0, 1, 0);
    step_a(0, 3'd1, 0, 8'h08, 0, 1, 1);
    step_a(0, 3'd1, 0, 8'h00, 1, 0, 1);
    step_a(0, 3'd1, 0, 8'h00, 0, 0, 1);

    // Back-to-back: 0 then 7 with valid held high; 7 ignored until ready
    step_a(1, 3'd0, 0, 8'h01, 0, 1, 0);
    step_a(1, 3'd7, 0, 8'h01, 0, 1, 0);
    step_a(1, 3'd7, 0, 8'h01, 0, 1, 0);
    step_a(1, 3'd7, 0, 8'h01, 0, 1, 1);
    step_a(1, 3'd7, 0, 8'h80, 1, 1, 0);
    step_a(0, 3'd2, 0, 8'h80, 0, 1, 0);
    step_a(0, 3'd2, 0, 8'h80, 0, 1, 0);
    step_a(0, 3'd2, 0, 8'h80, 0, 1, 1);
    step_a(0, 3'd2, 0, 8'h00, 1, 0, 1);
    step_a(0, 3'd2, 0, 8'h00, 0, 0, 1);

    // Flush on the second hold cycle; flush also blocks a transfer while idle
    step_a(1, 3'd6, 0, 8'h40, 0, 1, 0);
    step_a(0, 3'd6, 0, 8'h40, 0, 1, 0);
    step_a(1, 3'd2, 1, 8'h00, 0, 0, 1);
    step_a(1, 3'd2, 1, 8'h00, 0, 0, 1);
    step_a(0, 3'd2, 0, 8'h00, 0, 0, 1);

    // Asynchronous reset mid-hold
    step_a(1, 3'd6, 0, 8'h40, 0, 1, 0);
    step_a(0, 3'd6, 0, 8'h40, 0, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step_a(0, 3'd6, 0, 8'h00, 0, 0, 1);
    step_a(0, 3'd6, 0, 8'h00, 0, 0, 1);

    // HOLD=1 streaming of codes 0..7
    for (int k = 0; k < 8; k++)
      step_b(1, 3'(k), 8'(1 << k), (k >= 1), 1, 1);
    step_b(0, 3'd0, 8'h00, 1, 0, 1);
    step_b(0, 3'd0, 8'h00, 0, 0, 1);

    // N=4, HOLD=2: every code
    for (int k = 0; k < 16; k++) begin
      step_c(1, 4'(k), 16'(1 << k), 0, 1, 0);
      step_c(0, 4'(k), 16'(1 << k), 0, 1, 1);
      step_c(0, 4'(k), 16'h0000, 1, 0, 1);
    end

    repeat (3) @(negedge clk);
    cmp("drain", 16'(qa.size() + qb.size() + qc.size()), 16'h0000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
